// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared encodings and helpers for the load/store unit
// Holds the Store/Load size codes shared with the main decoder, fault codes,
// FSM state encoding and the size/byte-enable helpers.
package lsu_pkg;

  localparam logic [1:0] ST_B  = 2'b00;
  localparam logic [1:0] ST_H  = 2'b01;
  localparam logic [1:0] ST_W  = 2'b10;

  localparam logic [2:0] LD_B  = 3'b000;
  localparam logic [2:0] LD_H  = 3'b001;
  localparam logic [2:0] LD_W  = 3'b010;
  localparam logic [2:0] LD_BU = 3'b100;
  localparam logic [2:0] LD_HU = 3'b101;

  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_ILLEGAL  = 2'b10;
  localparam logic [1:0] FAULT_TIMEOUT  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  // Access width class; SZ_BAD marks an unlisted size code.
  typedef enum logic [1:0] {
    SZ_B   = 2'b00,
    SZ_H   = 2'b01,
    SZ_W   = 2'b10,
    SZ_BAD = 2'b11
  } size_t;

  function automatic size_t store_size(input logic [1:0] st);
    case (st)
      ST_B:    return SZ_B;
      ST_H:    return SZ_H;
      ST_W:    return SZ_W;
      default: return SZ_BAD;
    endcase
  endfunction

  function automatic size_t load_size(input logic [2:0] ld);
    case (ld)
      LD_B, LD_BU: return SZ_B;
      LD_H, LD_HU: return SZ_H;
      LD_W:        return SZ_W;
      default:     return SZ_BAD;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input size_t sz, input logic [1:0] off);
    case (sz)
      SZ_B:    return 4'b0001 << off;
      SZ_H:    return 4'b0011 << off;
      SZ_W:    return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// rtl/lsu_mem_ctrl_if.sv - data-memory bus between the LSU and memory
// master: mem_req, mem_we, mem_addr, mem_be, mem_wdata out; mem_ready, mem_rdata in
// slave : the mirror image, used by the memory model
interface lsu_mem_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic              mem_ready;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/lsu_load_align.sv
// rtl/lsu_load_align.sv - shifts and extends bus read data for a load
// mem_rdata_i : raw 32-bit bus word
// offset_i    : byte offset inside the word
// load_code_i : Load size code (lb/lh/lw/lbu/lhu)
// rdata_o     : aligned, sign/zero-extended result; 0 for unlisted codes
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] mem_rdata_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  load_code_i,
  output logic [31:0] rdata_o
);

  logic [31:0] shifted;

  assign shifted = mem_rdata_i >> {offset_i, 3'b000};

  always_comb begin
    rdata_o = 32'h0;
    case (load_code_i)
      LD_B:    rdata_o = {{24{shifted[7]}}, shifted[7:0]};
      LD_H:    rdata_o = {{16{shifted[15]}}, shifted[15:0]};
      LD_W:    rdata_o = shifted;
      LD_BU:   rdata_o = {24'h0, shifted[7:0]};
      LD_HU:   rdata_o = {16'h0, shifted[15:0]};
      default: rdata_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - load/store unit between execute and the data-memory bus
// clk, reset_n       : clock, asynchronous active-low reset
// start              : memory op valid, held by the core while stall=1
// is_store/Store/Load: op direction and size codes from the decoder
// addr, wdata        : byte address and store data
// stall              : freeze pipeline while an op is accepted or in flight
// done               : one-cycle completion pulse; rdata_out/fault_cause valid with it
// bus                : data-memory request/ready bus (master side)
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              is_store,
  input  logic [1:0]        Store,
  input  logic [2:0]        Load,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              stall,
  output logic              done,
  output logic [31:0]       rdata_out,
  output logic [1:0]        fault_cause,
  lsu_mem_ctrl_if.master    bus
);

  // Counter only has to reach TIMEOUT, so it can never wrap.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W:0] TO_LIMIT = (CNT_W + 1)'(TIMEOUT);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [1:0]        off_q, off_d;
  logic [2:0]        ld_q, ld_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [1:0]        fault_q, fault_d;

  size_t             sz;
  logic              illegal;
  logic              misaligned;
  logic [31:0]       wdata_rep;
  logic [CNT_W:0]    cnt_inc;
  logic [31:0]       load_ext;

  assign sz         = is_store ? store_size(Store) : load_size(Load);
  assign illegal    = (sz == SZ_BAD);
  assign misaligned = ((sz == SZ_H) && addr[0]) ||
                      ((sz == SZ_W) && (addr[1:0] != 2'b00));
  assign cnt_inc    = {1'b0, cnt_q} + 1'b1;

  always_comb begin
    wdata_rep = wdata;
    case (sz)
      SZ_B:    wdata_rep = {4{wdata[7:0]}};
      SZ_H:    wdata_rep = {2{wdata[15:0]}};
      default: wdata_rep = wdata;
    endcase
  end

  lsu_load_align u_align (
    .mem_rdata_i (bus.mem_rdata),
    .offset_i    (off_q),
    .load_code_i (ld_q),
    .rdata_o     (load_ext)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    off_d   = off_q;
    ld_d    = ld_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    fault_d = fault_q;

    case (state_q)
      S_IDLE: begin
        // mem_ready is deliberately ignored here.
        if (start) begin
          rdata_d = 32'h0;
          if (illegal) begin
            fault_d = FAULT_ILLEGAL;
            state_d = S_DONE;
          end else if (misaligned) begin
            fault_d = FAULT_MISALIGN;
            state_d = S_DONE;
          end else begin
            addr_d  = {addr[ADDR_W-1:2], 2'b00};
            we_d    = is_store;
            be_d    = byte_en(sz, addr[1:0]);
            wdata_d = is_store ? wdata_rep : 32'h0;
            off_d   = addr[1:0];
            ld_d    = Load;
            cnt_d   = '0;
            state_d = S_REQ;
          end
        end
      end

      S_REQ: begin
        if (bus.mem_ready) begin
          rdata_d = we_q ? 32'h0 : load_ext;
          fault_d = FAULT_NONE;
          state_d = S_DONE;
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_inc[CNT_W-1:0];
          // cnt_inc == TIMEOUT means this is the TIMEOUT-th cycle with mem_req high.
          if (cnt_inc == TO_LIMIT) begin
            rdata_d = 32'h0;
            fault_d = FAULT_TIMEOUT;
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        // start is not looked at; results are cleared after their one valid cycle.
        rdata_d = 32'h0;
        fault_d = FAULT_NONE;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= 4'h0;
      wdata_q <= 32'h0;
      off_q   <= 2'b00;
      ld_q    <= 3'b000;
      cnt_q   <= '0;
      rdata_q <= 32'h0;
      fault_q <= 2'b00;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      off_q   <= off_d;
      ld_q    <= ld_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
    end
  end

  // reset_n gates stall so it drops at once even if the core still holds start.
  assign stall         = reset_n && (((state_q == S_IDLE) && start) || (state_q == S_REQ));
  assign done          = (state_q == S_DONE);
  assign rdata_out     = rdata_q;
  assign fault_cause   = fault_q;
  assign bus.mem_req   = (state_q == S_REQ);
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_be    = be_q;
  assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb/tb_lsu_mem_ctrl.sv - self-checking bench for lsu_mem_ctrl
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        is_store = 1'b0;
  logic [1:0]  Store = 2'b00;
  logic [2:0]  Load = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        stall;
  logic        done;
  logic [31:0] rdata_out;
  logic [1:0]  fault_cause;

  int n_assert = 0;
  int n_fail   = 0;

  lsu_mem_ctrl_if #(.ADDR_W(32)) bus ();

  lsu_mem_ctrl #(.ADDR_W(32), .TIMEOUT(4)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .is_store    (is_store),
    .Store       (Store),
    .Load        (Load),
    .addr        (addr),
    .wdata       (wdata),
    .stall       (stall),
    .done        (done),
    .rdata_out   (rdata_out),
    .fault_cause (fault_cause),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_store;
    logic [1:0]  st;
    logic [2:0]  ld;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ready_at;   // REQ cycle (1-based) in which mem_ready is raised; 0 = never
    int          exp_req;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [1:0]  exp_fault;
    logic [31:0] exp_rdata;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v, input string tag);
    int req_cnt = 0;
    int cyc = 0;
    bit seen_done = 0;
    bit stable = 1;
    @(negedge clk);
    start = 1'b1; is_store = v.is_store; Store = v.st; Load = v.ld;
    addr = v.addr; wdata = v.wdata; bus.mem_rdata = v.rdata; bus.mem_ready = 1'b0;
    #1 chk({tag, "_stall_accept"}, 32'(stall), 32'd1);
    while (!seen_done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        seen_done = 1;
        chk({tag, "_fault"}, 32'(fault_cause), 32'(v.exp_fault));
        chk({tag, "_rdata"}, rdata_out, v.exp_rdata);
        chk({tag, "_stall_done"}, 32'(stall), 32'd0);
        start = 1'b0;
        bus.mem_ready = 1'b0;
      end else if (bus.mem_req) begin
        req_cnt++;
        if (req_cnt == 1) begin
          chk({tag, "_addr"}, bus.mem_addr, v.exp_addr);
          chk({tag, "_be"}, 32'(bus.mem_be), 32'(v.exp_be));
          chk({tag, "_we"}, 32'(bus.mem_we), 32'(v.is_store));
          chk({tag, "_wdata"}, bus.mem_wdata, v.exp_wdata);
        end else if (bus.mem_addr !== v.exp_addr || bus.mem_be !== v.exp_be ||
                     bus.mem_wdata !== v.exp_wdata || bus.mem_we !== v.is_store) begin
          stable = 0;
        end
        bus.mem_ready = (v.ready_at == req_cnt);
      end
    end
    chk({tag, "_done_seen"}, 32'(seen_done), 32'd1);
    chk({tag, "_req_cycles"}, 32'(req_cnt), 32'(v.exp_req));
    chk({tag, "_latency"}, 32'(cyc), 32'(v.exp_req + 1));
    if (req_cnt > 1) chk({tag, "_bus_stable"}, 32'(stable), 32'd1);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'h0;

    //           st  Store  Load    addr          wdata         mem_rdata     rdy req exp_addr      be       exp_wdata     flt    exp_rdata
    vecs[0]  = '{1, 2'b10, 3'b000, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,        3, 3, 32'h0000_0100, 4'b1111, 32'hDEAD_BEEF, 2'b00, 32'h0};
    vecs[1]  = '{1, 2'b00, 3'b000, 32'h0000_0103, 32'h0000_00A5, 32'h0,        1, 1, 32'h0000_0100, 4'b1000, 32'hA5A5_A5A5, 2'b00, 32'h0};
    vecs[2]  = '{1, 2'b01, 3'b000, 32'h0000_0102, 32'h1234_BEEF, 32'h0,        2, 2, 32'h0000_0100, 4'b1100, 32'hBEEF_BEEF, 2'b00, 32'h0};
    vecs[3]  = '{0, 2'b00, 3'b000, 32'h0000_0202, 32'h0,         32'h12F4_5678, 1, 1, 32'h0000_0200, 4'b0100, 32'h0,         2'b00, 32'hFFFF_FFF4};
    vecs[4]  = '{0, 2'b00, 3'b100, 32'h0000_0202, 32'h0,         32'h12F4_5678, 1, 1, 32'h0000_0200, 4'b0100, 32'h0,         2'b00, 32'h0000_00F4};
    vecs[5]  = '{0, 2'b00, 3'b001, 32'h0000_0202, 32'h0,         32'h12F4_5678, 1, 1, 32'h0000_0200, 4'b1100, 32'h0,         2'b00, 32'h0000_12F4};
    vecs[6]  = '{0, 2'b00, 3'b101, 32'h0000_0202, 32'h0,         32'h12F4_5678, 1, 1, 32'h0000_0200, 4'b1100, 32'h0,         2'b00, 32'h0000_12F4};
    vecs[7]  = '{0, 2'b00, 3'b000, 32'h0000_0201, 32'h0,         32'h12F4_5678, 1, 1, 32'h0000_0200, 4'b0010, 32'h0,         2'b00, 32'h0000_0056};
    vecs[8]  = '{0, 2'b00, 3'b010, 32'h0000_0204, 32'h0,         32'hCAFE_F00D, 2, 2, 32'h0000_0204, 4'b1111, 32'h0,         2'b00, 32'hCAFE_F00D};
    vecs[9]  = '{0, 2'b00, 3'b001, 32'h0000_01FE, 32'h0,         32'h8001_1234, 1, 1, 32'h0000_01FC, 4'b1100, 32'h0,         2'b00, 32'hFFFF_8001};
    vecs[10] = '{0, 2'b00, 3'b010, 32'h0000_0101, 32'h0,         32'h0,        1, 0, 32'h0,         4'b0000, 32'h0,         2'b01, 32'h0};
    vecs[11] = '{1, 2'b01, 3'b000, 32'h0000_0101, 32'h0000_1234, 32'h0,        1, 0, 32'h0,         4'b0000, 32'h0,         2'b01, 32'h0};
    vecs[12] = '{1, 2'b11, 3'b000, 32'h0000_0100, 32'h0000_1234, 32'h0,        1, 0, 32'h0,         4'b0000, 32'h0,         2'b10, 32'h0};
    vecs[13] = '{0, 2'b00, 3'b011, 32'h0000_0101, 32'h0,         32'h0,        1, 0, 32'h0,         4'b0000, 32'h0,         2'b10, 32'h0};
    vecs[14] = '{0, 2'b00, 3'b110, 32'h0000_0003, 32'h0,         32'h0,        1, 0, 32'h0,         4'b0000, 32'h0,         2'b10, 32'h0};
    vecs[15] = '{0, 2'b00, 3'b010, 32'h0000_0300, 32'h0,         32'h5555_AAAA, 0, 4, 32'h0000_0300, 4'b1111, 32'h0,         2'b11, 32'h0};
    vecs[16] = '{1, 2'b10, 3'b000, 32'h0000_0304, 32'h0BAD_F00D, 32'h0,        0, 4, 32'h0000_0304, 4'b1111, 32'h0BAD_F00D, 2'b11, 32'h0};

    // Reset state.
    #12;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_req", 32'(bus.mem_req), 32'd0);
    chk("rst_be", 32'(bus.mem_be), 32'd0);
    chk("rst_fault", 32'(fault_cause), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < NV; i++) run_op(vecs[i], $sformatf("v%0d", i));

    // mem_ready in IDLE without start must do nothing.
    @(negedge clk);
    bus.mem_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("idle_ready_req", 32'(bus.mem_req), 32'd0);
      chk("idle_ready_done", 32'(done), 32'd0);
    end
    bus.mem_ready = 1'b0;

    // start held through DONE is ignored: FSM returns to IDLE, not REQ.
    @(negedge clk);
    start = 1'b1; is_store = 1'b0; Load = 3'b010; addr = 32'h0000_0101;
    @(negedge clk);
    chk("dstart_done", 32'(done), 32'd1);
    chk("dstart_fault", 32'(fault_cause), 32'd1);
    @(negedge clk);
    chk("dstart_done_clr", 32'(done), 32'd0);
    chk("dstart_req", 32'(bus.mem_req), 32'd0);
    chk("dstart_stall", 32'(stall), 32'd1);
    start = 1'b0;

    // Asynchronous reset during the 2nd REQ cycle.
    @(negedge clk);
    start = 1'b1; is_store = 1'b1; Store = 2'b10; addr = 32'h0000_0040; wdata = 32'h1111_2222;
    @(negedge clk);
    chk("arst_req1", 32'(bus.mem_req), 32'd1);
    @(negedge clk);
    chk("arst_req2", 32'(bus.mem_req), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("arst_req_drop", 32'(bus.mem_req), 32'd0);
    chk("arst_stall_drop", 32'(stall), 32'd0);
    chk("arst_be_clr", 32'(bus.mem_be), 32'd0);
    start = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    run_op('{0, 2'b00, 3'b010, 32'h0, 32'h0, 32'h89AB_CDEF, 1, 1, 32'h0, 4'b1111, 32'h0, 2'b00, 32'h89AB_CDEF}, "post_rst_lw");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
